// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage VGA test-pattern pipeline with frame-boundary mode switching
// Optional macro VGA_PATTERN_BORDER_EN forces the visible screen edge to solid red in every mode.
module vga_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CW       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   input  logic          frame_start,
   input  logic          video_on,
   input  logic [9:0]    hcount,
   input  logic [9:0]    vcount,
   input  logic [1:0]    state,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue,
   output logic [1:0]    active_mode,
   output logic          mode_changed
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [1:0]    r_active_mode;
   logic          r_mode_changed;
   logic [7:0]    r_frame_cnt;
   logic [9:0]    r_s1_h;
   logic [9:0]    r_s1_v;
   logic          r_s1_vid;
   logic [1:0]    r_s1_mode;
   logic [CW-1:0] r_red;
   logic [CW-1:0] r_green;
   logic [CW-1:0] r_blue;

   logic          w_fire;
   logic [1:0]    w_mode_in;
   logic [2:0]    w_bar;
   logic          w_border;
   logic          w_cross;
   logic [3:0]    w_anim_r;
   logic [CW-1:0] w_red;
   logic [CW-1:0] w_green;
   logic [CW-1:0] w_blue;

   // The mode latched on a frame_start tick must already govern the pixel entering S1 that tick.
   assign w_fire    = pix_en && frame_start;
   assign w_mode_in = w_fire ? state : r_active_mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active_mode  <= 2'd0;
         r_mode_changed <= 1'b0;
         r_frame_cnt    <= 8'd0;
         r_s1_h         <= 10'd0;
         r_s1_v         <= 10'd0;
         r_s1_vid       <= 1'b0;
         r_s1_mode      <= 2'd0;
         r_red          <= '0;
         r_green        <= '0;
         r_blue         <= '0;
      end else begin
         r_mode_changed <= 1'b0;
         if (w_fire) begin
            r_active_mode  <= state;
            r_mode_changed <= (state != r_active_mode);
            r_frame_cnt    <= r_frame_cnt + 8'd1;
         end
         if (pix_en) begin
            r_s1_h    <= hcount;
            r_s1_v    <= vcount;
            r_s1_vid  <= video_on;
            r_s1_mode <= w_mode_in;
            r_red     <= w_red;
            r_green   <= w_green;
            r_blue    <= w_blue;
         end
      end
   end

   always_comb begin
      w_bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (int'(r_s1_h) >= i * BAR_W) w_bar = 3'(i);
      end
      w_border = (r_s1_h == 10'd0) || (int'(r_s1_h) == H_ACTIVE - 1) ||
                 (r_s1_v == 10'd0) || (int'(r_s1_v) == V_ACTIVE - 1);
      w_cross  = (int'(r_s1_h) == H_ACTIVE / 2 - 1) || (int'(r_s1_h) == H_ACTIVE / 2) ||
                 (int'(r_s1_v) == V_ACTIVE / 2 - 1) || (int'(r_s1_v) == V_ACTIVE / 2) ||
                 w_border;
      w_anim_r = r_s1_h[7:4] + r_frame_cnt[3:0];

      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
      case (r_s1_mode)
         // Bar colour bits map directly onto inverted bits of the bar index.
         2'd0: begin
            w_red   = {CW{~w_bar[1]}};
            w_green = {CW{~w_bar[2]}};
            w_blue  = {CW{~w_bar[0]}};
         end
         2'd1: begin
            w_red   = {CW{w_cross}};
            w_green = {CW{w_cross}};
            w_blue  = {CW{w_cross}};
         end
         2'd2: begin
            w_red   = {CW{r_s1_h[0] ^ r_s1_v[0]}};
            w_green = {CW{r_s1_h[0] ^ r_s1_v[0]}};
            w_blue  = {CW{r_s1_h[0] ^ r_s1_v[0]}};
         end
         default: begin
            w_red   = CW'(w_anim_r);
            w_green = CW'(r_s1_v[7:4]);
            w_blue  = CW'(r_frame_cnt[7:4]);
         end
      endcase

`ifdef VGA_PATTERN_BORDER_EN
      if (w_border) begin
         w_red   = '1;
         w_green = '0;
         w_blue  = '0;
      end
`endif

      if (!r_s1_vid) begin
         w_red   = '0;
         w_green = '0;
         w_blue  = '0;
      end
   end

   assign red          = r_red;
   assign green        = r_green;
   assign blue         = r_blue;
   assign active_mode  = r_active_mode;
   assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed self-checking bench for vga_pattern_gen
// Expected edge colours follow VGA_PATTERN_BORDER_EN when it is defined.
module tb_vga_pattern_gen;

`ifdef VGA_PATTERN_BORDER_EN
   localparam bit BORDER_ON = 1'b1;
`else
   localparam bit BORDER_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       pix_en;
   logic       frame_start;
   logic       video_on;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic [1:0] state;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic [1:0] active_mode;
   logic       mode_changed;
   logic [11:0] w_rgb;

   int n_checks = 0;
   int n_fail   = 0;

   assign w_rgb = {red, green, blue};

   vga_pattern_gen #(.H_ACTIVE(640), .V_ACTIVE(480), .CW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .frame_start (frame_start),
      .video_on    (video_on),
      .hcount      (hcount),
      .vcount      (vcount),
      .state       (state),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .active_mode (active_mode),
      .mode_changed(mode_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] edge_px(input logic [11:0] base);
      return BORDER_ON ? 12'hF00 : base;
   endfunction

   task automatic pix(input int h, input int v, input logic vid);
      pix_en      = 1'b1;
      frame_start = 1'b0;
      hcount      = 10'(h);
      vcount      = 10'(v);
      video_on    = vid;
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string tag, input int h, input int v, input logic vid,
                        input logic [11:0] exp);
      pix(h, v, vid);
      pix(h, v, vid);
      check(tag, w_rgb, exp);
   endtask

   task automatic fstart(input logic [1:0] st, input int h, input int v);
      state       = st;
      pix_en      = 1'b1;
      frame_start = 1'b1;
      hcount      = 10'(h);
      vcount      = 10'(v);
      video_on    = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; state = 2'd2; pix_en = 1'b1; frame_start = 1'b1;
      video_on = 1'b1; hcount = 10'd100; vcount = 10'd10;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", w_rgb, 12'h000);
      check("rst_mode", active_mode, 2'd0);
      check("rst_chg", mode_changed, 1'b0);
      rst = 1'b0; frame_start = 1'b0;

      // colour bars, first frame after reset
      probe("bar_h100", 100, 10, 1'b1, 12'hFF0);
      probe("bar_h79", 79, 10, 1'b1, 12'hFFF);
      probe("bar_h80", 80, 10, 1'b1, 12'hFF0);
      probe("bar_h559", 559, 10, 1'b1, 12'h00F);
      probe("bar_h560", 560, 10, 1'b1, 12'h000);
      probe("bar_h639", 639, 10, 1'b1, edge_px(12'h000));

      // mid-frame request is deferred to frame_start
      state = 2'd1;
      probe("midframe_h320", 320, 100, 1'b1, 12'hF0F);
      check("midframe_mode", active_mode, 2'd0);
      fstart(2'd1, 320, 100);
      check("fs1_mode", active_mode, 2'd1);
      check("fs1_chg", mode_changed, 1'b1);
      pix(320, 100, 1'b1);
      check("fs1_chg_clr", mode_changed, 1'b0);
      check("cross_sametick", w_rgb, 12'hFFF);
      probe("cross_100_100", 100, 100, 1'b1, 12'h000);
      probe("cross_h319", 319, 50, 1'b1, 12'hFFF);
      probe("cross_v239", 200, 239, 1'b1, 12'hFFF);
      probe("cross_v241", 200, 241, 1'b1, 12'h000);
      probe("cross_h639", 639, 100, 1'b1, edge_px(12'hFFF));

      fstart(2'd1, 0, 0);
      check("same_chg", mode_changed, 1'b0);
      check("same_mode", active_mode, 2'd1);

      // checkerboard, blanking, hold
      fstart(2'd2, 0, 0);
      check("fs2_chg", mode_changed, 1'b1);
      probe("chk_0_0", 0, 0, 1'b1, edge_px(12'h000));
      probe("chk_1_0", 1, 0, 1'b1, edge_px(12'hFFF));
      probe("chk_1_1", 1, 1, 1'b1, 12'h000);
      probe("chk_5_5", 5, 5, 1'b1, 12'h000);
      probe("chk_0_7", 0, 7, 1'b1, edge_px(12'hFFF));
      probe("blank_h700", 700, 5, 1'b0, 12'h000);
      probe("chk_3_4", 3, 4, 1'b1, 12'hFFF);
      pix_en = 1'b0; frame_start = 1'b1; state = 2'd3;
      hcount = 10'd700; vcount = 10'd0; video_on = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      frame_start = 1'b0;
      check("hold_rgb", w_rgb, 12'hFFF);
      check("hold_mode", active_mode, 2'd2);
      check("hold_chg", mode_changed, 1'b0);

      // animation: four frame_starts so far, bring frame_cnt to 0x1F
      fstart(2'd3, 0, 0);
      check("fs3_chg", mode_changed, 1'b1);
      for (int i = 0; i < 27; i++) fstart(2'd3, 0, 0);
      probe("anim_1f", 48, 80, 1'b1, 12'h251);
      for (int i = 0; i < 225; i++) fstart(2'd3, 0, 0);
      probe("anim_wrap", 48, 80, 1'b1, 12'h350);
      check("anim_mode", active_mode, 2'd3);

      fstart(2'd0, 100, 10);
      check("fs0_chg", mode_changed, 1'b1);
      pix(100, 10, 1'b1);
      check("fs0_sametick", w_rgb, 12'hFF0);

      // reset mid-frame
      state = 2'd3;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_rgb", w_rgb, 12'h000);
      rst = 1'b0;
      fstart(2'd3, 0, 0);
      check("postrst_fs_mode", active_mode, 2'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst2_mode", active_mode, 2'd0);
      rst = 1'b0;
      probe("postrst_bar", 100, 10, 1'b1, 12'hFF0);
      check("postrst_mode", active_mode, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
